axi_to_gmii: RTL and testbench

Transmit-side counterpart of the GMII receive path: accepts a 64-bit AXI-Stream frame and serializes it onto an 8-bit GMII transmit interface, one byte per clock. It optionally prepends preamble/SFD, enforces a minimum inter-frame gap, and signals AXI underrun mid-frame with `gmii_tx_er`. Sits between the packet source (loopback or MAC-side logic) and the RGMII transmit PHY adapter, entirely in the GMII transmit clock domain.

---
 rtl/gmii_pkg.sv | 23 ++
 rtl/axis_beat_buffer.sv | 48 ++++
 rtl/axi_to_gmii.sv | 172 +++++++++++++++++
 tb/tb_axi_to_gmii.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_pkg.sv
// Shared GMII transmit constants, FSM state encoding and byte-lane helper.
package gmii_pkg;

  localparam logic [7:0] GMII_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] GMII_SFD_BYTE      = 8'hD5;
  localparam logic [7:0] GMII_PREAMBLE_LEN  = 8'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP,
    ST_IFG
  } tx_state_e;

  // A beat ends at lane 7 or at the first cleared keep bit above the current lane.
  function automatic logic is_final_byte(input logic [7:0] keep, input logic [2:0] idx);
    logic [2:0] nxt;
    nxt = idx + 3'd1;
    return (idx == 3'd7) || !keep[nxt];
  endfunction

endpackage

// File: rtl/axis_beat_buffer.sv
// Single-entry AXI-Stream beat holding register (NEXT); ready is the registered empty flag.
module axis_beat_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [63:0] i_data,
  input  logic [7:0]  i_keep,
  input  logic        i_last,
  input  logic        i_discard,
  input  logic        i_pop,
  output logic        o_ready,
  output logic        o_full,
  output logic [63:0] o_data,
  output logic [7:0]  o_keep,
  output logic        o_last
);

  logic        r_full;
  logic [63:0] r_data;
  logic [7:0]  r_keep;
  logic        r_last;
  logic        w_accept;

  assign o_ready  = !r_full;
  assign o_full   = r_full;
  assign o_data   = r_data;
  assign o_keep   = r_keep;
  assign o_last   = r_last;
  // Discarded beats are still handshaken but never occupy the register.
  assign w_accept = i_valid && !r_full && !i_discard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_data <= i_data;
      r_keep <= i_keep;
      r_last <= i_last;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_to_gmii.sv
// Serializes 64-bit AXI-Stream frames onto GMII TX, with optional preamble/SFD,
// minimum inter-frame gap and tx_er signalling of mid-frame AXI underrun.
module axi_to_gmii
  import gmii_pkg::*;
#(
  parameter bit          ADD_PREAMBLE = 1'b1,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic        gmii_tx_clk,
  input  logic        rst_n,
  input  logic        axis_tvalid,
  input  logic [63:0] axis_tdata,
  input  logic [7:0]  axis_tkeep,
  input  logic        axis_tlast,
  output logic        axis_tready,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [7:0]  gmii_txd,
  output logic        tx_underrun
);

  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

  tx_state_e   r_state;
  logic [7:0]  r_cnt;
  logic [63:0] r_sh_data;
  logic [7:0]  r_sh_keep;
  logic        r_sh_last;
  logic [2:0]  r_sh_idx;
  logic        r_err_pend;
  logic        r_tx_en;
  logic        r_tx_er;
  logic [7:0]  r_txd;
  logic        r_underrun;

  logic        w_next_full;
  logic [63:0] w_next_data;
  logic [7:0]  w_next_keep;
  logic        w_next_last;
  logic        w_next_empty_frame;
  logic        w_final;
  logic [7:0]  w_byte;
  logic        w_pop;
  logic        w_discard;
  logic        w_drop_last;

  axis_beat_buffer u_next (
    .clk       (gmii_tx_clk),
    .rst_n     (rst_n),
    .i_valid   (axis_tvalid),
    .i_data    (axis_tdata),
    .i_keep    (axis_tkeep),
    .i_last    (axis_tlast),
    .i_discard (w_discard),
    .i_pop     (w_pop),
    .o_ready   (axis_tready),
    .o_full    (w_next_full),
    .o_data    (w_next_data),
    .o_keep    (w_next_keep),
    .o_last    (w_next_last)
  );

  assign gmii_tx_en  = r_tx_en;
  assign gmii_tx_er  = r_tx_er;
  assign gmii_txd    = r_txd;
  assign tx_underrun = r_underrun;

  assign w_final            = is_final_byte(r_sh_keep, r_sh_idx);
  assign w_byte             = r_sh_data[{r_sh_idx, 3'b000} +: 8];
  assign w_next_empty_frame = w_next_last && !w_next_keep[0];
  assign w_discard          = (r_state == ST_DROP);
  assign w_drop_last        = w_discard && axis_tvalid && axis_tready && axis_tlast;

  // NEXT drains into SHIFT on frame start and at each beat boundary; an empty last beat is drained without loading.
  always_comb begin
    w_pop = 1'b0;
    if (w_next_full) begin
      if (r_state == ST_IDLE)
        w_pop = 1'b1;
      else if (r_state == ST_DATA && w_final && !r_sh_last)
        w_pop = 1'b1;
    end
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_sh_data  <= '0;
      r_sh_keep  <= '0;
      r_sh_last  <= 1'b0;
      r_sh_idx   <= '0;
      r_err_pend <= 1'b0;
      r_tx_en    <= 1'b0;
      r_tx_er    <= 1'b0;
      r_txd      <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_tx_en    <= 1'b0;
      r_tx_er    <= 1'b0;
      r_txd      <= '0;
      r_underrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_next_full) begin
            r_cnt <= '0;
            if (w_next_empty_frame) begin
              r_state <= ST_IFG;
            end else begin
              r_sh_data <= w_next_data;
              r_sh_keep <= w_next_keep;
              r_sh_last <= w_next_last;
              r_sh_idx  <= '0;
              r_state   <= ADD_PREAMBLE ? ST_PREAMBLE : ST_DATA;
            end
          end
        end
        ST_PREAMBLE: begin
          r_tx_en <= 1'b1;
          r_txd   <= (r_cnt == GMII_PREAMBLE_LEN) ? GMII_SFD_BYTE : GMII_PREAMBLE_BYTE;
          if (r_cnt == GMII_PREAMBLE_LEN) begin
            r_cnt   <= '0;
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DATA: begin
          r_tx_en <= 1'b1;
          r_txd   <= w_byte;
          if (!w_final) begin
            r_sh_idx <= r_sh_idx + 3'd1;
          end else if (r_sh_last || (w_next_full && w_next_empty_frame)) begin
            r_cnt   <= '0;
            r_state <= ST_IFG;
          end else if (w_next_full) begin
            r_sh_data <= w_next_data;
            r_sh_keep <= w_next_keep;
            r_sh_last <= w_next_last;
            r_sh_idx  <= '0;
          end else begin
            r_err_pend <= 1'b1;
            r_state    <= ST_DROP;
          end
        end
        ST_DROP: begin
          // First DROP cycle carries the single tx_er byte that terminates the frame.
          if (r_err_pend) begin
            r_tx_en    <= 1'b1;
            r_tx_er    <= 1'b1;
            r_underrun <= 1'b1;
            r_err_pend <= 1'b0;
          end
          if (w_drop_last) begin
            r_cnt   <= '0;
            r_state <= ST_IFG;
          end
        end
        ST_IFG: begin
          if (r_cnt == IFG_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_to_gmii.sv
// Directed/randomized bench for axi_to_gmii: GMII output is logged per cycle and split into
// tx_en runs, which are compared against frames built from the AXI beats sent.
module tb_axi_to_gmii;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        axis_tvalid;
  logic [63:0] axis_tdata;
  logic [7:0]  axis_tkeep;
  logic        axis_tlast;
  logic        axis_tready;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic [7:0]  gmii_txd;
  logic        tx_underrun;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  axi_to_gmii #(.ADD_PREAMBLE(1'b1), .IFG_BYTES(12)) dut (
    .gmii_tx_clk (clk),
    .rst_n       (rst_n),
    .axis_tvalid (axis_tvalid),
    .axis_tdata  (axis_tdata),
    .axis_tkeep  (axis_tkeep),
    .axis_tlast  (axis_tlast),
    .axis_tready (axis_tready),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er),
    .gmii_txd    (gmii_txd),
    .tx_underrun (tx_underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] txd;
    logic       und;
    logic       rdy;
  } samp_t;

  samp_t      log_q[$];
  int         run_start[$];
  int         run_len[$];
  int         run_off[$];
  logic [8:0] run_bytes[$];
  logic [8:0] exp_q[$];

  // Sample index k holds the outputs just after the k-th logged rising edge.
  always @(posedge clk) begin
    #1;
    log_q.push_back('{gmii_tx_en, gmii_tx_er, gmii_txd, tx_underrun, axis_tready});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, output int acc);
    int unsigned waited;
    waited      = 0;
    axis_tvalid = 1'b1;
    axis_tdata  = d;
    axis_tkeep  = k;
    axis_tlast  = l;
    while (axis_tready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) chk("tready_timeout", axis_tready, 1);
    acc = log_q.size();
    @(negedge clk);
  endtask

  task automatic analyze();
    run_start.delete();
    run_len.delete();
    run_off.delete();
    run_bytes.delete();
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].en) begin
        if (i == 0 || !log_q[i-1].en) begin
          run_start.push_back(i);
          run_len.push_back(0);
          run_off.push_back(run_bytes.size());
        end
        run_len[run_len.size()-1]++;
        run_bytes.push_back({log_q[i].er, log_q[i].txd});
      end
    end
  endtask

  function automatic int count_er();
    int c = 0;
    foreach (log_q[i]) if (log_q[i].er) c++;
    return c;
  endfunction

  function automatic int count_und();
    int c = 0;
    foreach (log_q[i]) if (log_q[i].und) c++;
    return c;
  endfunction

  function automatic int count_idle_nonzero();
    int c = 0;
    foreach (log_q[i]) if (!log_q[i].en && log_q[i].txd != 8'h00) c++;
    return c;
  endfunction

  task automatic exp_preamble();
    for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
  endtask

  task automatic exp_beat(input logic [63:0] d, input logic [7:0] k);
    for (int i = 0; i < 8; i++) begin
      if (!k[i]) break;
      exp_q.push_back({1'b0, d[8*i +: 8]});
    end
  endtask

  task automatic check_run(input string tag, input int r);
    longint obs;
    if (r >= run_start.size()) begin
      chk({tag, "_present"}, run_start.size(), r + 1);
      return;
    end
    chk({tag, "_len"}, run_len[r], exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < run_len[r]) ? longint'(run_bytes[run_off[r] + i]) : -1;
      chk($sformatf("%s_b%0d", tag, i), obs, exp_q[i]);
    end
  endtask

  function automatic int gap(input int r);
    if (r + 1 >= run_start.size()) return -1;
    return run_start[r+1] - (run_start[r] + run_len[r]);
  endfunction

  initial begin
    int a1, a2, a3, a4, a5, a6;
    logic [63:0] d1, d2, d3, d4;
    int ready_cnt;

    rst_n       = 1'b0;
    axis_tvalid = 1'b0;
    axis_tdata  = '0;
    axis_tkeep  = '0;
    axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_en", gmii_tx_en, 0);
    chk("rst_tx_er", gmii_tx_er, 0);
    chk("rst_txd", gmii_txd, 0);
    chk("rst_underrun", tx_underrun, 0);
    chk("rst_tready", axis_tready, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single full beat with preamble.
    log_q.delete();
    exp_q.delete();
    send_beat(64'h0706050403020100, 8'hFF, 1'b1, a1);
    axis_tvalid = 1'b0;
    repeat (40) @(negedge clk);
    analyze();
    exp_preamble();
    exp_beat(64'h0706050403020100, 8'hFF);
    chk("A_runs", run_start.size(), 1);
    check_run("A", 0);
    chk("A_latency", run_start[0], a1 + 2);
    chk("A_idle_after_ge12", (log_q.size() - (run_start[0] + run_len[0])) >= 12, 1);
    chk("A_er_count", count_er(), 0);
    chk("A_idle_txd_zero", count_idle_nonzero(), 0);

    // Three-beat frame, tvalid held, last beat keep 07.
    log_q.delete();
    exp_q.delete();
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    d3 = {$urandom, $urandom};
    send_beat(d1, 8'hFF, 1'b0, a1);
    send_beat(d2, 8'hFF, 1'b0, a2);
    send_beat(d3, 8'h07, 1'b1, a3);
    axis_tvalid = 1'b0;
    repeat (50) @(negedge clk);
    analyze();
    exp_preamble();
    exp_beat(d1, 8'hFF);
    exp_beat(d2, 8'hFF);
    exp_beat(d3, 8'h07);
    chk("B_runs", run_start.size(), 1);
    check_run("B", 0);
    chk("B_latency", run_start[0], a1 + 2);
    chk("B_beat3_accept", a3, run_start[0] + 16);
    ready_cnt = 0;
    for (int i = a2; i < a3; i++) if (log_q[i].rdy) ready_cnt++;
    chk("B_tready_pulses", ready_cnt, 1);
    chk("B_er_count", count_er(), 0);

    // Underrun: second beat withheld, late beats dropped through tlast, next frame clean.
    log_q.delete();
    exp_q.delete();
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    send_beat(d1, 8'hFF, 1'b0, a1);
    axis_tvalid = 1'b0;
    repeat (20) @(negedge clk);
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0, a2);
    send_beat({$urandom, $urandom}, 8'hFF, 1'b1, a3);
    axis_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    send_beat(d2, 8'h3F, 1'b1, a4);
    axis_tvalid = 1'b0;
    repeat (60) @(negedge clk);
    analyze();
    chk("C_runs", run_start.size(), 2);
    exp_preamble();
    exp_beat(d1, 8'hFF);
    exp_q.push_back(9'h100);
    check_run("C_abort", 0);
    exp_q.delete();
    exp_preamble();
    exp_beat(d2, 8'h3F);
    check_run("C_next", 1);
    chk("C_er_count", count_er(), 1);
    chk("C_und_count", count_und(), 1);
    chk("C_und_at_err_byte", log_q[run_start[0] + run_len[0] - 1].und, 1);
    chk("C_late_beat_no_stall", a3, a2 + 1);
    chk("C_gap_ge13", gap(0) >= 13, 1);
    chk("C_idle_txd_zero", count_idle_nonzero(), 0);

    // Back-to-back frames: empty last beat, plain single beat, 1-byte tail.
    log_q.delete();
    exp_q.delete();
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    d3 = {$urandom, $urandom};
    d4 = {$urandom, $urandom};
    send_beat(d1, 8'hFF, 1'b0, a1);
    send_beat({$urandom, $urandom}, 8'h00, 1'b1, a2);
    send_beat(d2, 8'hFF, 1'b1, a3);
    send_beat(d3, 8'hFF, 1'b0, a4);
    send_beat(d4, 8'h01, 1'b1, a5);
    axis_tvalid = 1'b0;
    repeat (60) @(negedge clk);
    analyze();
    chk("D_runs", run_start.size(), 3);
    exp_preamble();
    exp_beat(d1, 8'hFF);
    check_run("D_keep00", 0);
    exp_q.delete();
    exp_preamble();
    exp_beat(d2, 8'hFF);
    check_run("D_f2", 1);
    exp_q.delete();
    exp_preamble();
    exp_beat(d3, 8'hFF);
    exp_beat(d4, 8'h01);
    check_run("D_f3", 2);
    chk("D_gap01", gap(0), 13);
    chk("D_gap12", gap(1), 13);
    chk("D_er_count", count_er(), 0);

    // Asynchronous reset in the middle of DATA.
    log_q.delete();
    exp_q.delete();
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0, a1);
    send_beat({$urandom, $urandom}, 8'hFF, 1'b1, a2);
    axis_tvalid = 1'b0;
    repeat (10) @(negedge clk);
    chk("F_busy_before_reset", gmii_tx_en, 1);
    rst_n = 1'b0;
    #1;
    chk("F_rst_tx_en", gmii_tx_en, 0);
    chk("F_rst_tx_er", gmii_tx_er, 0);
    chk("F_rst_txd", gmii_txd, 0);
    chk("F_rst_und", tx_underrun, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("F_tready_after", axis_tready, 1);
    log_q.delete();
    repeat (30) @(negedge clk);
    analyze();
    chk("F_no_residual_tx", run_start.size(), 0);
    chk("F_no_er", count_er(), 0);
    log_q.delete();
    d1 = {$urandom, $urandom};
    send_beat(d1, 8'h0F, 1'b1, a6);
    axis_tvalid = 1'b0;
    repeat (40) @(negedge clk);
    analyze();
    exp_preamble();
    exp_beat(d1, 8'h0F);
    chk("F_runs", run_start.size(), 1);
    check_run("F_new", 0);
    chk("F_latency", run_start[0], a6 + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
